// File: rtl/log_capture_ctrl_pkg.sv
// Shared definitions for the TX-sample logging controller.
// Holds the RAM geometry, the FSM state encoding and the micro command codes
// used by the file register when it talks to this block.
package log_capture_ctrl_pkg;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = 1024;
  localparam int NB_ADDR   = 10;
  localparam int NB_DECIM  = 4;
  localparam int NB_RDADDR = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [7:0] RUN_MEM = 8'h05;
  localparam logic [7:0] RD_MEM  = 8'h06;
  localparam logic [7:0] IS_FULL = 8'h07;

endpackage

// File: rtl/log_capture_ctrl_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// No reset on storage or read data so it maps onto block RAM.
// Ports:
//   clock    in  system clock
//   we       in  write enable
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read enable; rd_data updates only when high
//   rd_addr  in  read address
//   rd_data  out registered read data
module log_dpram #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int NB_ADDR = 10
) (
  input  logic               clock,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/log_capture_ctrl.sv
// Logging memory sequencer for the BPSK TX path.
// A rising edge on i_run_log captures decimated I/Q sample words into the
// internal RAM until it is full; afterwards the file register reads it back.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no capture since reset, reads served
//   ST_CAPTURE | storing qualified samples, reads ignored
//   ST_FULL    | RAM holds RAM_DEPTH words, reads served
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   i_run_log     run level; rising edge starts/restarts a capture
//   i_read_log    read request level, one read per high cycle
//   i_addr_log    read address (>= RAM_DEPTH reads back zero)
//   i_data_tx     sample word to log
//   i_sample_en   i_data_tx valid this cycle
//   i_decim       keep every (i_decim+1)-th qualified sample
//   o_data_log    read data, 2 cycles after an accepted read
//   o_mem_full    capture complete
//   o_busy        capture in progress
//   o_wr_count    words written in the current/last run
module log_capture_ctrl
  import log_capture_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_run_log,
  input  logic                 i_read_log,
  input  logic [NB_RDADDR-1:0] i_addr_log,
  input  logic [RAM_WIDTH-1:0] i_data_tx,
  input  logic                 i_sample_en,
  input  logic [NB_DECIM-1:0]  i_decim,
  output logic [RAM_WIDTH-1:0] o_data_log,
  output logic                 o_mem_full,
  output logic                 o_busy,
  output logic [NB_ADDR:0]     o_wr_count
);

  localparam logic [NB_ADDR:0]   WR_COUNT_MAX = (NB_ADDR+1)'(RAM_DEPTH);
  localparam logic [NB_ADDR-1:0] LAST_ADDR    = NB_ADDR'(RAM_DEPTH - 1);

  state_t               state;
  logic                 run_d;
  logic [NB_ADDR-1:0]   wr_ptr;
  logic [NB_DECIM-1:0]  decim_cnt;
  logic [NB_DECIM-1:0]  decim_val;
  logic                 run_rise;
  logic                 store;
  logic                 rd_accept;
  logic                 rd_oob;
  logic                 rd_valid;
  logic                 rd_zero;
  logic [RAM_WIDTH-1:0] ram_q;

  assign run_rise = i_run_log & ~run_d;

  // Samples arriving in the same cycle as a restart are dropped; the first
  // qualified sample after the restart is the first one stored.
  assign store = (state == ST_CAPTURE) && !run_rise && i_sample_en
                 && (decim_cnt == '0);

  assign rd_accept = i_read_log && !run_rise && (state != ST_CAPTURE) && !reset;
  assign rd_oob    = i_addr_log >= NB_RDADDR'(RAM_DEPTH);

  log_dpram #(
    .WIDTH   (RAM_WIDTH),
    .DEPTH   (RAM_DEPTH),
    .NB_ADDR (NB_ADDR)
  ) u_dpram (
    .clock   (clock),
    .we      (store && !reset),
    .wr_addr (wr_ptr),
    .wr_data (i_data_tx),
    .rd_en   (rd_accept && !rd_oob),
    .rd_addr (i_addr_log[NB_ADDR-1:0]),
    .rd_data (ram_q)
  );

  // Decimator runs as a down-counter: store on zero, then reload with the
  // ratio latched at run start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      run_d      <= 1'b0;
      wr_ptr     <= '0;
      decim_cnt  <= '0;
      decim_val  <= '0;
      o_wr_count <= '0;
      o_mem_full <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      run_d <= i_run_log;
      if (run_rise) begin
        state      <= ST_CAPTURE;
        wr_ptr     <= '0;
        decim_cnt  <= '0;
        decim_val  <= i_decim;
        o_wr_count <= '0;
        o_mem_full <= 1'b0;
        o_busy     <= 1'b1;
      end else if (state == ST_CAPTURE && i_sample_en) begin
        decim_cnt <= (decim_cnt == '0) ? decim_val : decim_cnt - 1'b1;
        if (store) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (o_wr_count != WR_COUNT_MAX) o_wr_count <= o_wr_count + 1'b1;
          if (wr_ptr == LAST_ADDR) begin
            state      <= ST_FULL;
            o_busy     <= 1'b0;
            o_mem_full <= 1'b1;
          end
        end
      end
    end
  end

  // Read pipe: RAM output register, then output register. Out-of-range
  // addresses skip the RAM and force zero in the second stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_zero    <= 1'b0;
      o_data_log <= '0;
    end else begin
      rd_valid <= rd_accept;
      rd_zero  <= rd_oob;
      if (rd_valid) o_data_log <= rd_zero ? '0 : ram_q;
    end
  end

endmodule
